// File: rtl/page_stream_in_q_pkg.sv
// Shared definitions for the page stream input queue: default sizes,
// token/occupancy width helpers and the per-cycle queue operation code.
package page_stream_in_q_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int SLACK_DEF  = 1;

    // Per-cycle queue operation, encoded as {enq, deq}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    // A token is {data, eos}: eos sits in the LSB, matching the output queues.
    function automatic int token_w(input int data_w);
        return data_w + 1;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/page_stream_in_q_if.sv
// Handshake bundle of one page input stream: interconnect side (qin_*),
// operator side (qout_*) and status flags.
interface page_stream_in_q_if
    import page_stream_in_q_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int OCC_W = occ_w(DEPTH);

    logic [DATA_W-1:0] qin_d;
    logic              qin_e;
    logic              qin_v;
    logic              qin_b;
    logic [DATA_W-1:0] qout_d;
    logic              qout_e;
    logic              qout_v;
    logic              qout_b;
    logic [OCC_W-1:0]  occ;
    logic              eos_seen;
    logic              ovf;

    // Queue view.
    modport slave (
        input  qin_d, qin_e, qin_v, qout_b,
        output qin_b, qout_d, qout_e, qout_v, occ, eos_seen, ovf
    );

    // Environment view: sender plus consumer.
    modport master (
        output qin_d, qin_e, qin_v, qout_b,
        input  qin_b, qout_d, qout_e, qout_v, occ, eos_seen, ovf
    );
endinterface

// File: rtl/page_stream_in_q_regfile.sv
// DEPTH x TOKEN_W token store: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module page_stream_in_q_regfile #(
    parameter int TOKEN_W = 17,
    parameter int DEPTH   = 4,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [TOKEN_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [TOKEN_W-1:0] o_rdata
);
    logic [TOKEN_W-1:0] r_mem [DEPTH];

    // Write the incoming token into its slot.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/page_stream_in_q.sv
// Receiver-side per-stream input queue. Accepts {data,eos} tokens from the
// interconnect, raises back-pressure SLACK slots early so tokens already in
// flight still fit, and presents the head token to the operator input port.
// No bypass: a token written at one edge appears on qout after that edge.
module page_stream_in_q
    import page_stream_in_q_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SLACK  = SLACK_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    page_stream_in_q_if.slave     s_if
);
    localparam int TOKEN_W = token_w(DATA_W);
    localparam int OCC_W   = occ_w(DEPTH);
    localparam int AW      = $clog2(DEPTH);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_eos_seen;
    logic               r_ovf;

    logic               w_full;
    logic               w_qout_v;
    logic               w_deq;
    logic               w_enq;
    logic               w_drop;
    q_op_e              w_op;
    logic [TOKEN_W-1:0] w_wr_tok;
    logic [TOKEN_W-1:0] w_rd_tok;

    // Full/empty come from occupancy; the pointers alone are ambiguous.
    assign w_full   = (r_occ == OCC_W'(DEPTH));
    assign w_qout_v = !i_rst && (r_occ != '0);
    assign w_deq    = w_qout_v && !s_if.qout_b;
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_enq    = !i_rst && s_if.qin_v && (!w_full || w_deq);
    assign w_drop   = !i_rst && s_if.qin_v && w_full && !w_deq;
    assign w_op     = q_op_e'({w_enq, w_deq});
    assign w_wr_tok = {s_if.qin_d, s_if.qin_e};

    page_stream_in_q_regfile #(
        .TOKEN_W (TOKEN_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_tok),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_tok)
    );

    // Pointers, occupancy and sticky status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_eos_seen <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case (w_op)
                OP_ENQ:  r_occ <= r_occ + OCC_W'(1);
                OP_DEQ:  r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_deq && w_rd_tok[0]) begin
                r_eos_seen <= 1'b1;
            end
        end
    end

    // Back-pressure depends only on registered occupancy (and reset), so the
    // pipelined b wire never sees a path from qin_v or qout_b.
    assign s_if.qin_b    = i_rst || (r_occ >= OCC_W'(DEPTH - SLACK));
    assign s_if.qout_v   = w_qout_v;
    assign s_if.qout_d   = w_rd_tok[TOKEN_W-1:1];
    assign s_if.qout_e   = w_rd_tok[0];
    assign s_if.occ      = r_occ;
    assign s_if.eos_seen = r_eos_seen;
    assign s_if.ovf      = r_ovf;
endmodule

// File: tb/tb_page_stream_in_q.sv
// Directed bench for page_stream_in_q (DATA_W=16, DEPTH=4, SLACK=1).
module tb_page_stream_in_q;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    page_stream_in_q_if #(.DATA_W(16), .DEPTH(4)) bus ();

    page_stream_in_q #(.DATA_W(16), .DEPTH(4), .SLACK(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [16:0] expq[$];
    logic [16:0] exp_tok;
    logic [15:0] pat;
    int          sent;
    int          got;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.qin_d = 16'h0055;
        bus.qin_e = 1'b0;
        bus.qin_v = 1'b1;
        bus.qout_b = 1'b0;

        // Reset held two cycles while a token is offered.
        tick();
        check("rst1_qin_b", bus.qin_b, 1);
        check("rst1_qout_v", bus.qout_v, 0);
        check("rst1_occ", bus.occ, 0);
        check("rst1_ovf", bus.ovf, 0);
        tick();
        check("rst2_qin_b", bus.qin_b, 1);
        check("rst2_occ", bus.occ, 0);
        check("rst2_ovf", bus.ovf, 0);
        check("rst2_eos", bus.eos_seen, 0);
        rst = 1'b0;
        bus.qin_v = 1'b0;
        #1;
        check("rel_qin_b", bus.qin_b, 0);
        check("rel_qout_v", bus.qout_v, 0);
        tick();
        check("rel_occ", bus.occ, 0);

        // Streaming 1..8 with consumer always ready.
        bus.qout_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus.qin_d = 16'(i);
            bus.qin_v = 1'b1;
            tick();
            check("stream_v", bus.qout_v, 1);
            check("stream_d", bus.qout_d, i);
            check("stream_occ", bus.occ, 1);
        end
        bus.qin_v = 1'b0;
        tick();
        check("stream_empty_v", bus.qout_v, 0);
        check("stream_empty_occ", bus.occ, 0);

        // Fill with consumer stalled; fourth token rides on the slack.
        bus.qout_b = 1'b1;
        bus.qin_v = 1'b1;
        bus.qin_d = 16'h0010; tick();
        check("fill1_occ", bus.occ, 1);
        bus.qin_d = 16'h0011; tick();
        check("fill2_occ", bus.occ, 2);
        check("fill2_qin_b", bus.qin_b, 0);
        bus.qin_d = 16'h0012; tick();
        check("fill3_occ", bus.occ, 3);
        check("fill3_qin_b", bus.qin_b, 1);
        bus.qin_d = 16'h0013; tick();
        check("fill4_occ", bus.occ, 4);
        check("fill4_ovf", bus.ovf, 0);
        check("fill4_head", bus.qout_d, 16'h0010);

        // Overflow: one more token at full with no dequeue.
        bus.qin_d = 16'h0099; tick();
        check("ovf_occ", bus.occ, 4);
        check("ovf_flag", bus.ovf, 1);
        check("ovf_head", bus.qout_d, 16'h0010);
        bus.qin_v = 1'b0;
        bus.qout_b = 1'b0;
        tick();
        check("ovf_drain1", bus.qout_d, 16'h0011);
        check("ovf_drain1_occ", bus.occ, 3);
        tick();
        check("ovf_drain2", bus.qout_d, 16'h0012);
        tick();
        check("ovf_drain3", bus.qout_d, 16'h0013);
        tick();
        check("ovf_drained_occ", bus.occ, 0);
        check("ovf_sticky", bus.ovf, 1);

        // Reset clears the sticky overflow.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst3_ovf", bus.ovf, 0);
        check("rst3_occ", bus.occ, 0);

        // Full queue with simultaneous enqueue and dequeue.
        bus.qout_b = 1'b1;
        bus.qin_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.qin_d = 16'(16'h0020 + i);
            tick();
        end
        check("full_occ", bus.occ, 4);
        bus.qout_b = 1'b0;
        bus.qin_d = 16'h0024; tick();
        check("both1_occ", bus.occ, 4);
        check("both1_head", bus.qout_d, 16'h0021);
        check("both1_ovf", bus.ovf, 0);
        bus.qin_d = 16'h0025; tick();
        check("both2_occ", bus.occ, 4);
        check("both2_head", bus.qout_d, 16'h0022);
        bus.qin_v = 1'b0;
        tick();
        check("both_drain1", bus.qout_d, 16'h0023);
        check("both_drain1_occ", bus.occ, 3);
        tick();
        check("both_drain2", bus.qout_d, 16'h0024);
        tick();
        check("both_drain3", bus.qout_d, 16'h0025);
        tick();
        check("both_empty_occ", bus.occ, 0);
        check("both_ovf", bus.ovf, 0);

        // EOS and pointer wrap: 10 tokens, last with eos, patterned stalls.
        pat  = 16'b1010_0110_0011_1001;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            bus.qout_b = pat[cyc % 16];
            if (sent < 10 && !bus.qin_b) begin
                bus.qin_v = 1'b1;
                bus.qin_d = 16'(16'h0030 + sent);
                bus.qin_e = (sent == 9);
                expq.push_back({bus.qin_d, bus.qin_e});
                sent++;
            end else begin
                bus.qin_v = 1'b0;
                bus.qin_e = 1'b0;
            end
            #1;
            if (bus.qout_v && !bus.qout_b) begin
                exp_tok = expq.pop_front();
                check("eos_d", bus.qout_d, exp_tok[16:1]);
                check("eos_e", bus.qout_e, exp_tok[0]);
                check("eos_pre", bus.eos_seen, 0);
                got++;
            end
            tick();
        end
        bus.qin_v = 1'b0;
        bus.qin_e = 1'b0;
        check("eos_count", got, 10);
        check("eos_seen", bus.eos_seen, 1);
        check("eos_occ", bus.occ, 0);

        // Tokens after eos are queued normally.
        bus.qout_b = 1'b1;
        bus.qin_v = 1'b1;
        bus.qin_d = 16'h0040;
        tick();
        bus.qin_v = 1'b0;
        check("post_eos_v", bus.qout_v, 1);
        check("post_eos_d", bus.qout_d, 16'h0040);
        check("post_eos_sticky", bus.eos_seen, 1);
        bus.qout_b = 1'b0;
        tick();
        check("post_eos_occ", bus.occ, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
